// File: rtl/fp_addsub_param_if.sv
// Request/result bundle for the parametrised floating-point add/subtract unit.
// The master issues operands; the slave returns the registered result and flags.
interface fp_addsub_param_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] sum;
  logic         done;
  logic         busy;
  logic         flag_invalid;
  logic         flag_overflow;
  logic         flag_inexact;

  modport master (
    output start, sub, a, b,
    input  sum, done, busy, flag_invalid, flag_overflow, flag_inexact
  );

  modport slave (
    input  start, sub, a, b,
    output sum, done, busy, flag_invalid, flag_overflow, flag_inexact
  );
endinterface

// File: rtl/fp_addsub_param.sv
// Multi-cycle IEEE-754 add/subtract with RNE rounding, subnormals and exception flags.
// Fixed latency: accept in IDLE, result and done appear six cycles later in PACK.
module fp_addsub_param #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic              clk,
  input  logic              reset,
  fp_addsub_param_if.slave  bus
);
  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned MW   = MAN_W + 5;          // carry, hidden, fraction, G, R, S
  localparam int unsigned EW   = EXP_W + 2;
  localparam int unsigned RW   = MAN_W + 2;          // rounding carry + hidden + fraction
  localparam int unsigned EMAX = (1 << EXP_W) - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_PACK
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic            sub_q, sub_d;
  logic            sa_q, sa_d, sb_q, sb_d;
  logic [EW-1:0]   ea_q, ea_d, eb_q, eb_d;
  logic [MW-1:0]   ma_q, ma_d, mb_q, mb_d;
  logic            spec_q, spec_d, spec_inv_q, spec_inv_d;
  logic [W-1:0]    spec_val_q, spec_val_d;
  logic            zero_q, zero_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            done_q, done_d, busy_q, busy_d;
  logic            inv_q, inv_d, ovf_q, ovf_d, inx_q, inx_d;

  // Combinational scratch
  logic            a_all1, b_all1, a_exp_nz, b_exp_nz, nan_a, nan_b, inf_a, inf_b, sbe;
  logic            swap, inc;
  logic [EW-1:0]   ex, ey, dexp, er;
  logic [MW-1:0]   mx, my, ysh, ymsk;
  logic [RW-1:0]   rnd;
  int unsigned     lz, room, sh;

  // Leading zeros from the hidden-bit position downwards
  function automatic int unsigned lzc_f(input logic [MW-2:0] m);
    int unsigned n;
    logic        found;
    n     = 0;
    found = 1'b0;
    for (int i = int'(MW) - 2; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1'b1;
        else      n++;
      end
    end
    return n;
  endfunction

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sub_d      = sub_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    ea_d       = ea_q;
    eb_d       = eb_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    spec_d     = spec_q;
    spec_inv_d = spec_inv_q;
    spec_val_d = spec_val_q;
    zero_d     = zero_q;
    sum_d      = sum_q;
    inv_d      = inv_q;
    ovf_d      = ovf_q;
    inx_d      = inx_q;
    done_d     = 1'b0;
    busy_d     = 1'b0;
    a_all1     = &a_q[W-2:MAN_W];
    b_all1     = &b_q[W-2:MAN_W];
    a_exp_nz   = |a_q[W-2:MAN_W];
    b_exp_nz   = |b_q[W-2:MAN_W];
    nan_a      = a_all1 & (|a_q[MAN_W-1:0]);
    nan_b      = b_all1 & (|b_q[MAN_W-1:0]);
    inf_a      = a_all1 & ~(|a_q[MAN_W-1:0]);
    inf_b      = b_all1 & ~(|b_q[MAN_W-1:0]);
    sbe        = b_q[W-1] ^ sub_q;
    swap       = 1'b0;
    inc        = 1'b0;
    ex         = '0;
    ey         = '0;
    dexp       = '0;
    er         = '0;
    mx         = '0;
    my         = '0;
    ysh        = '0;
    ymsk       = '0;
    rnd        = '0;
    lz         = 0;
    room       = 0;
    sh         = 0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sub_d   = bus.sub;
          state_d = S_UNPACK;
        end
      end

      // Subnormals get exponent 1 and no hidden bit; specials are resolved here
      S_UNPACK: begin
        sa_d       = a_q[W-1];
        sb_d       = sbe;
        ea_d       = a_exp_nz ? EW'(a_q[W-2:MAN_W]) : EW'(1);
        eb_d       = b_exp_nz ? EW'(b_q[W-2:MAN_W]) : EW'(1);
        ma_d       = {1'b0, a_exp_nz, a_q[MAN_W-1:0], 3'b000};
        mb_d       = {1'b0, b_exp_nz, b_q[MAN_W-1:0], 3'b000};
        zero_d     = 1'b0;
        spec_d     = a_all1 | b_all1;
        spec_inv_d = 1'b0;
        if (nan_a || nan_b || (inf_a && inf_b && (a_q[W-1] != sbe))) begin
          spec_val_d = QNAN;
          spec_inv_d = 1'b1;
        end else if (inf_a) begin
          spec_val_d = {a_q[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
          spec_val_d = {sbe, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
        state_d = S_ALIGN;
      end

      // X takes the larger magnitude; Y is shifted right with G/R/S retained
      S_ALIGN: begin
        swap = (eb_q > ea_q) || ((eb_q == ea_q) && (mb_q > ma_q));
        ex   = swap ? eb_q : ea_q;
        ey   = swap ? ea_q : eb_q;
        mx   = swap ? mb_q : ma_q;
        my   = swap ? ma_q : mb_q;
        dexp = ex - ey;
        if (32'(dexp) >= MAN_W + 3) begin
          ysh    = '0;
          ysh[0] = |my;
        end else begin
          ysh    = my >> dexp;
          ymsk   = (MW'(1) << dexp) - MW'(1);
          ysh[0] = ysh[0] | (|(my & ymsk));
        end
        sa_d    = swap ? sb_q : sa_q;
        sb_d    = swap ? sa_q : sb_q;
        ea_d    = ex;
        eb_d    = ey;
        ma_d    = mx;
        mb_d    = ysh;
        state_d = S_ADD;
      end

      S_ADD: begin
        ma_d    = (sa_q == sb_q) ? (ma_q + mb_q) : (ma_q - mb_q);
        state_d = S_NORM;
      end

      // Left shift is capped so the exponent never drops below 1 (subnormal floor)
      S_NORM: begin
        zero_d = (ma_q == '0);
        if (ma_q[MW-1]) begin
          ma_d = {1'b0, ma_q[MW-1:2], ma_q[1] | ma_q[0]};
          ea_d = ea_q + EW'(1);
        end else begin
          lz   = lzc_f(ma_q[MW-2:0]);
          room = 32'(ea_q) - 32'd1;
          sh   = (lz < room) ? lz : room;
          ma_d = ma_q << sh;
          ea_d = ea_q - EW'(sh);
        end
        state_d = S_ROUND;
      end

      // Round to nearest even and pack straight into the result registers
      S_ROUND: begin
        inc = ma_q[2] & (ma_q[1] | ma_q[0] | ma_q[3]);
        rnd = {1'b0, ma_q[MAN_W+3:3]} + RW'(inc);
        er  = ea_q;
        if (rnd[RW-1]) begin
          rnd = rnd >> 1;
          er  = ea_q + EW'(1);
        end
        inv_d = 1'b0;
        ovf_d = 1'b0;
        inx_d = 1'b0;
        if (spec_q) begin
          sum_d = spec_val_q;
          inv_d = spec_inv_q;
        end else if (zero_q) begin
          sum_d = {sa_q & sb_q, {(W-1){1'b0}}};
        end else if (er >= EW'(EMAX)) begin
          sum_d = {sa_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d = 1'b1;
          inx_d = 1'b1;
        end else begin
          sum_d = {sa_q, rnd[MAN_W] ? er[EXP_W-1:0] : {EXP_W{1'b0}}, rnd[MAN_W-1:0]};
          inx_d = |ma_q[2:0];
        end
        state_d = S_PACK;
      end

      S_PACK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_PACK);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      ea_q       <= '0;
      eb_q       <= '0;
      ma_q       <= '0;
      mb_q       <= '0;
      spec_q     <= 1'b0;
      spec_inv_q <= 1'b0;
      spec_val_q <= '0;
      zero_q     <= 1'b0;
      sum_q      <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      inv_q      <= 1'b0;
      ovf_q      <= 1'b0;
      inx_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sub_q      <= sub_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      ea_q       <= ea_d;
      eb_q       <= eb_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      spec_q     <= spec_d;
      spec_inv_q <= spec_inv_d;
      spec_val_q <= spec_val_d;
      zero_q     <= zero_d;
      sum_q      <= sum_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      inv_q      <= inv_d;
      ovf_q      <= ovf_d;
      inx_q      <= inx_d;
    end
  end

  assign bus.sum           = sum_q;
  assign bus.done          = done_q;
  assign bus.busy          = busy_q;
  assign bus.flag_invalid  = inv_q;
  assign bus.flag_overflow = ovf_q;
  assign bus.flag_inexact  = inx_q;
endmodule

// File: tb/tb_fp_addsub_param.sv
// Bench for fp_addsub_param: single- and half-precision instances, vector table,
// scoreboard queues checked on done, plus hold-start and mid-operation reset sequences.
module tb_fp_addsub_param;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_addsub_param_if #(.EXP_W(8), .MAN_W(23)) bus_s ();
  fp_addsub_param_if #(.EXP_W(5), .MAN_W(10)) bus_h ();

  fp_addsub_param #(.EXP_W(8), .MAN_W(23)) dut_s (.clk(clk), .reset(reset), .bus(bus_s));
  fp_addsub_param #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .reset(reset), .bus(bus_h));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic [2:0]  flags;   // {invalid, overflow, inexact}
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic [2:0]  flags;
    int          acc;
  } sb_t;

  sb_t q_s[$];
  sb_t q_h[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  cyc = 0;
  int  done_cnt_s = 0;
  int  done_cnt_h = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
  endtask

  // Single-precision result monitor
  always @(posedge clk) begin : mon_s
    sb_t e;
    #1;
    if (bus_s.done) begin
      done_cnt_s++;
      check("sp done expected", 32'(q_s.size() != 0), 32'd1);
      if (q_s.size() != 0) begin
        e = q_s.pop_front();
        check("sp sum", bus_s.sum, e.sum);
        check("sp flags", 32'({bus_s.flag_invalid, bus_s.flag_overflow, bus_s.flag_inexact}),
              32'(e.flags));
        check("sp latency", 32'(cyc - e.acc), 32'd5);
      end
    end
  end

  // Half-precision result monitor
  always @(posedge clk) begin : mon_h
    sb_t e;
    #1;
    if (bus_h.done) begin
      done_cnt_h++;
      check("hp done expected", 32'(q_h.size() != 0), 32'd1);
      if (q_h.size() != 0) begin
        e = q_h.pop_front();
        check("hp sum", 32'(bus_h.sum), e.sum);
        check("hp flags", 32'({bus_h.flag_invalid, bus_h.flag_overflow, bus_h.flag_inexact}),
              32'(e.flags));
        check("hp latency", 32'(cyc - e.acc), 32'd5);
      end
    end
  end

  task automatic run_s(input vec_t v);
    sb_t e;
    int  k;
    k = 0;
    while (bus_s.busy && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (bus_s.busy) check("sp idle wait", 32'(bus_s.busy), 32'd0);
    @(negedge clk);
    bus_s.a = v.a; bus_s.b = v.b; bus_s.sub = v.sub; bus_s.start = 1'b1;
    @(posedge clk); #1;
    e.sum = v.sum; e.flags = v.flags; e.acc = cyc;
    q_s.push_back(e);
    bus_s.start = 1'b0;
  endtask

  task automatic run_h(input vec_t v);
    sb_t e;
    int  k;
    k = 0;
    while (bus_h.busy && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (bus_h.busy) check("hp idle wait", 32'(bus_h.busy), 32'd0);
    @(negedge clk);
    bus_h.a = 16'(v.a); bus_h.b = 16'(v.b); bus_h.sub = v.sub; bus_h.start = 1'b1;
    @(posedge clk); #1;
    e.sum = v.sum; e.flags = v.flags; e.acc = cyc;
    q_h.push_back(e);
    bus_h.start = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q_s.size() != 0 || q_h.size() != 0) && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain", 32'(q_s.size() + q_h.size()), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vs[18];
    vec_t vh[3];
    sb_t  e;
    int   d0;
    logic all_busy;

    vs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000};
    vs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000};
    vs[2]  = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000};
    vs[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001};
    vs[4]  = '{32'h3F800000, 32'h34400000, 1'b0, 32'h3F800002, 3'b001};
    vs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011};
    vs[6]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100};
    vs[7]  = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000};
    vs[8]  = '{32'h00400000, 32'h00400000, 1'b0, 32'h00800000, 3'b000};
    vs[9]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000};
    vs[10] = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100};
    vs[11] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000};
    vs[12] = '{32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 3'b000};
    vs[13] = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 3'b000};
    vs[14] = '{32'h3F800000, 32'h3F800001, 1'b0, 32'h40000000, 3'b001};
    vs[15] = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 3'b000};
    vs[16] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000};
    vs[17] = '{32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 3'b001};

    vh[0]  = '{32'h3C00, 32'h4000, 1'b0, 32'h4200, 3'b000};
    vh[1]  = '{32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 3'b011};
    vh[2]  = '{32'h3C00, 32'h3C00, 1'b1, 32'h0000, 3'b000};

    reset = 1'b1;
    bus_s.start = 1'b0; bus_s.sub = 1'b0; bus_s.a = '0; bus_s.b = '0;
    bus_h.start = 1'b0; bus_h.sub = 1'b0; bus_h.a = '0; bus_h.b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("sp reset outputs", 32'({bus_s.sum, bus_s.done, bus_s.busy, bus_s.flag_invalid,
          bus_s.flag_overflow, bus_s.flag_inexact} != '0), 32'd0);
    check("hp reset outputs", 32'({bus_h.sum, bus_h.done, bus_h.busy, bus_h.flag_invalid,
          bus_h.flag_overflow, bus_h.flag_inexact}), 32'd0);
    @(negedge clk) reset = 1'b0;

    foreach (vs[i]) run_s(vs[i]);
    drain();
    foreach (vh[i]) run_h(vh[i]);
    drain();

    // start held high for the whole operation: exactly one accept, busy T+1..T+6
    d0 = done_cnt_s;
    all_busy = 1'b1;
    @(negedge clk);
    bus_s.a = vs[0].a; bus_s.b = vs[0].b; bus_s.sub = vs[0].sub; bus_s.start = 1'b1;
    @(posedge clk); #1;
    e.sum = vs[0].sum; e.flags = vs[0].flags; e.acc = cyc;
    q_s.push_back(e);
    for (int i = 0; i < 6; i++) begin
      if (!bus_s.busy) all_busy = 1'b0;
      if (i < 5) begin
        @(posedge clk); #1;
      end
    end
    check("busy T+1..T+6", 32'(all_busy), 32'd1);
    @(negedge clk) bus_s.start = 1'b0;
    @(posedge clk); #1;
    check("busy low at T+7", 32'(bus_s.busy), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("one done while start held", 32'(done_cnt_s - d0), 32'd1);
    drain();

    // Reset during ALIGN aborts; a fresh request right after completes normally
    d0 = done_cnt_s;
    @(negedge clk);
    bus_s.a = vs[9].a; bus_s.b = vs[9].b; bus_s.sub = vs[9].sub; bus_s.start = 1'b1;
    @(posedge clk);
    @(negedge clk) bus_s.start = 1'b0;
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("reset in ALIGN outputs", 32'({bus_s.sum, bus_s.done, bus_s.busy, bus_s.flag_invalid,
          bus_s.flag_overflow, bus_s.flag_inexact} != '0), 32'd0);
    check("reset in ALIGN sum", bus_s.sum, 32'd0);
    @(negedge clk) reset = 1'b0;
    run_s(vs[4]);
    drain();
    repeat (4) @(posedge clk);
    #1;
    check("no done from aborted op", 32'(done_cnt_s - d0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fp_addsub_param.md
Name: fp_addsub_param

Overview:
Parametrised, multi-cycle IEEE-754 floating-point add/subtract unit for the datapath arithmetic cluster. It generalises the single-precision adder in four ways: configurable exponent and mantissa widths, an add/subtract mode, round-to-nearest-even with exception flags, and full subnormal support. A small FSM sequences the operation with a fixed latency for all operands, so the issuing controller needs no special-case tracking.

Parameters:
EXP_W, 8, exponent field width (≥3)
MAN_W, 23, stored fraction width (≥2); word width W = 1+EXP_W+MAN_W

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
sub  in  1  0 = a+b, 1 = a−b; captured with operands
a  in  W  operand A, captured when start is accepted
b  in  W  operand B, captured when start is accepted
sum  out  W  result; registered, held until the next done
done  out  1  one-cycle pulse when sum/flags are valid
busy  out  1  high whenever the FSM is not in IDLE
flag_invalid  out  1  inf−inf or signalling/any NaN input; valid with done
flag_overflow  out  1  rounded result exceeded max finite
flag_inexact  out  1  guard, round or sticky bit was nonzero

Behaviour:
- Reset: one clock, synchronous, active-high; the already-decided port names are clk and reset.
  - On the cycle after reset is sampled high, all outputs are 0 and the state is IDLE.
  - Reset in any state aborts the operation; no done pulse follows.
- States: IDLE → UNPACK → ALIGN → ADD → NORM → ROUND → PACK → IDLE.
  - Each non-IDLE state lasts exactly one cycle.
- Accept: in cycle T, state is IDLE and start=1.
  - a, b, sub are registered and the next state is UNPACK.
  - start in any other state is ignored, with no queuing.
- Timing:
  - busy is high in cycles T+1..T+6.
  - done pulses in cycle T+6 (PACK); sum and flags update in that same cycle.
  - The earliest next accept is T+7.
- Sticky outputs: sum and the flags keep their values between done pulses.
- UNPACK:
  - Effective b sign = b.sign XOR sub.
  - Exponent field 0 → subnormal: hidden bit 0, effective exponent 1.
  - Otherwise hidden bit 1.
  - Special classification (all-ones exponent):
    - Any NaN input → canonical quiet NaN: sign 0, exp all ones, fraction MSB 1, rest 0. Set flag_invalid.
    - inf + (−inf) after sub adjustment → canonical qNaN, flag_invalid.
    - Otherwise infinity → that infinity, no flags.
  - Special results bypass arithmetic but still complete at T+6.
- ALIGN:
  - Swap so operand X has the larger magnitude (exponent, then mantissa).
  - Right-shift Y's mantissa by the exponent difference, keeping 3 extra bits: guard, round, sticky.
  - Sticky = OR of all bits shifted beyond round; difference ≥ MAN_W+3 makes Y = 0 with sticky set if Y≠0.
- ADD:
  - Same effective signs → magnitude add; else X−Y (non-negative by construction).
  - Result sign = X's sign.
- NORM:
  - Carry out → shift right 1, exponent +1, sticky absorbs the lost bit.
  - Else leading-zero count, shift left by min(lzc, exp−1); exponent reduces accordingly. If exp reaches 1 with hidden bit 0, the result is subnormal (stored exp 0).
  - Exact zero magnitude → +0, except (−0)+(−0) → −0.
- ROUND (RNE):
  - Increment if G & (R | S | LSB).
  - Mantissa carry → renormalise and increment exponent; a subnormal rounding up to min normal becomes normal.
  - flag_inexact = G|R|S.
- Overflow: exponent ≥ all-ones → ±infinity, flag_overflow=1, flag_inexact=1.
- Widths: internal mantissa datapath is MAN_W+5 bits (carry, hidden, fraction, G, R, S); exponent arithmetic is EXP_W+2 bits signed.

Test Plan:
1. a=3F800000, b=40000000, sub=0, start pulsed → done exactly 6 cycles after accept, sum=40400000, flags 000.
2. a=3F800000, b=3F800000, sub=1 → sum=00000000 (+0), flags 000; a=80000000, b=00000000, sub=1 → sum=80000000.
3. a=3F800000, b=33800000 → sum=3F800000, inexact=1 (tie to even); a=3F800000, b=34400000 → sum=3F800002, inexact=1.
4. a=7F7FFFFF, b=7F7FFFFF → sum=7F800000, overflow=1, inexact=1; a=7F800000, b=7F800000, sub=1 → sum=7FC00000, invalid=1.
5. Subnormals: a=00000001, b=00000001 → 00000002; a=00400000, b=00400000 → 00800000 (becomes normal), flags 000.
6. Control: start held high during busy → only one done; reset asserted in ALIGN → no done, all outputs 0 the next cycle; new start accepted immediately afterwards completes normally. Rerun cases 1 and 4 with EXP_W=5, MAN_W=10 (half precision): 3C00+4000 → 4200; 7BFF+7BFF → 7C00.
